// File: rtl/tron_round_ctrl_pkg.sv
// Shared definitions for the light-cycle round sequencer: state and winner encodings,
// frame counter width and the default match length.
package tron_round_ctrl_pkg;

    localparam int FRAME_CNT_W       = 8;
    localparam int DEFAULT_WIN_SCORE = 5;

    // HUD and player blocks decode these values straight off the state port.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_COUNTDOWN = 3'd2;
    localparam logic [2:0] ST_PLAYING   = 3'd3;
    localparam logic [2:0] ST_ROUND_END = 3'd4;
    localparam logic [2:0] ST_GAME_OVER = 3'd5;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_DRAW = 2'd3
    } winner_t;

    function automatic logic is_timed_state(input logic [2:0] s);
        return (s == ST_COUNTDOWN) || (s == ST_PLAYING) || (s == ST_ROUND_END);
    endfunction

endpackage

// File: rtl/tron_round_ctrl_frame_timer.sv
// Frame-pulse counter with a reloadable terminal value; done fires combinationally with
// the terminal frame_end so the caller can act on the same clock edge.
module tron_round_ctrl_frame_timer
    import tron_round_ctrl_pkg::*;
(
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   frame_end,
    input  logic [FRAME_CNT_W-1:0] terminal,
    output logic                   done
);

    logic [FRAME_CNT_W-1:0] count_reg, count_next;

    assign done = enable && frame_end && (count_reg == terminal - 1'b1);

    always_comb begin
        count_next = count_reg;
        if (clear || done) begin
            count_next = '0;
        end else if (enable && frame_end) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/tron_round_ctrl.sv
// Round sequencer for the two-player light-cycle game: arena clear handshake, countdown,
// movement pacing, crash scoring and match winner. All outputs are registered.
module tron_round_ctrl
    import tron_round_ctrl_pkg::*;
#(
    parameter int STEP_FRAMES      = 4,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int ROUND_END_FRAMES = 120,
    parameter int WIN_SCORE        = DEFAULT_WIN_SCORE
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_end,
    input  logic       crash_p1,
    input  logic       crash_p2,
    input  logic       clear_done,
    output logic       clear_req,
    output logic       step_en,
    output logic       play_active,
    output logic [2:0] state,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner
);

    localparam logic [FRAME_CNT_W-1:0] STEP_TERM      = FRAME_CNT_W'(STEP_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] COUNTDOWN_TERM = FRAME_CNT_W'(COUNTDOWN_FRAMES);
    localparam logic [FRAME_CNT_W-1:0] ROUND_END_TERM = FRAME_CNT_W'(ROUND_END_FRAMES);
    localparam logic [3:0]             WIN_LIM        = 4'(WIN_SCORE);

    logic [2:0]             state_reg, state_next;
    winner_t                winner_reg, winner_next;
    logic                   clear_req_reg, step_en_reg, play_active_reg;
    logic                   step_next, zero_scores;
    logic [1:0]             crash_vec;
    logic [1:0][3:0]        score_vec;
    logic                   game_won;
    logic                   timer_en, timer_clear, timer_done;
    logic [FRAME_CNT_W-1:0] timer_terminal;

    assign crash_vec   = {crash_p2, crash_p1};
    assign game_won    = (score_vec[0] == WIN_LIM) || (score_vec[1] == WIN_LIM);
    assign timer_en    = is_timed_state(state_reg);
    // Every state entry restarts the frame count from zero.
    assign timer_clear = (state_next != state_reg);

    always_comb begin
        timer_terminal = STEP_TERM;
        case (state_reg)
            ST_COUNTDOWN: timer_terminal = COUNTDOWN_TERM;
            ST_ROUND_END: timer_terminal = ROUND_END_TERM;
            default:      timer_terminal = STEP_TERM;
        endcase
    end

    tron_round_ctrl_frame_timer u_frame_timer (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .clear     (timer_clear),
        .enable    (timer_en),
        .frame_end (frame_end),
        .terminal  (timer_terminal),
        .done      (timer_done)
    );

    always_comb begin
        state_next  = state_reg;
        winner_next = winner_reg;
        step_next   = 1'b0;
        zero_scores = 1'b0;
        case (state_reg)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    state_next  = ST_CLEAR;
                    zero_scores = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (clear_done) begin
                    state_next = ST_COUNTDOWN;
                end
            end
            ST_COUNTDOWN: begin
                if (timer_done) begin
                    state_next = ST_PLAYING;
                end
            end
            ST_PLAYING: begin
                // A crash pre-empts a coincident step frame.
                if (|crash_vec) begin
                    state_next = ST_ROUND_END;
                    if (&crash_vec) begin
                        winner_next = WIN_DRAW;
                    end else if (crash_p1) begin
                        winner_next = WIN_P2;
                    end else begin
                        winner_next = WIN_P1;
                    end
                end else if (timer_done) begin
                    step_next = 1'b1;
                end
            end
            ST_ROUND_END: begin
                if (timer_done) begin
                    state_next = game_won ? ST_GAME_OVER : ST_CLEAR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (zero_scores) begin
            winner_next = WIN_NONE;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            winner_reg      <= WIN_NONE;
            clear_req_reg   <= 1'b0;
            step_en_reg     <= 1'b0;
            play_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            winner_reg      <= winner_next;
            clear_req_reg   <= (state_next == ST_CLEAR);
            step_en_reg     <= step_next;
            play_active_reg <= (state_next == ST_PLAYING);
        end
    end

    // Player gi scores when only the opponent crashed; index 0 is P1, 1 is P2.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_score
            logic       point_won;
            logic [3:0] score_reg, score_next;

            assign point_won = (state_reg == ST_PLAYING) && crash_vec[1-gi] && !crash_vec[gi];

            always_comb begin
                score_next = score_reg;
                if (zero_scores) begin
                    score_next = 4'd0;
                end else if (point_won && (score_reg < WIN_LIM)) begin
                    score_next = score_reg + 4'd1;
                end
            end

            always_ff @(posedge CLOCK_50) begin
                if (reset) begin
                    score_reg <= 4'd0;
                end else begin
                    score_reg <= score_next;
                end
            end

            assign score_vec[gi] = score_reg;
        end
    endgenerate

    assign state       = state_reg;
    assign winner      = winner_reg;
    assign clear_req   = clear_req_reg;
    assign step_en     = step_en_reg;
    assign play_active = play_active_reg;
    assign score_p1    = score_vec[0];
    assign score_p2    = score_vec[1];

endmodule

// File: tb/tb_tron_round_ctrl.sv
// Self-checking bench for tron_round_ctrl: directed scenarios plus a randomized run, all
// compared against a frame-counting reference model of the round rules.
module tb_tron_round_ctrl;

    localparam int STEP_FRAMES      = 2;
    localparam int COUNTDOWN_FRAMES = 3;
    localparam int ROUND_END_FRAMES = 2;
    localparam int WIN_SCORE        = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0, start = 1'b0, frame_end = 1'b0;
    logic       crash_p1 = 1'b0, crash_p2 = 1'b0, clear_done = 1'b0;
    logic       clear_req, step_en, play_active;
    logic [2:0] state;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;
    logic [15:0] dut_vec;

    int pass_count = 0;
    int check_count = 0;
    int step_seen = 0;

    // Reference model: 0 idle, 1 clear, 2 countdown, 3 playing, 4 round end, 5 game over.
    int m_state = 0, m_frames = 0, m_s1 = 0, m_s2 = 0, m_winner = 0;
    bit m_clear_req = 0, m_step = 0, m_play = 0;

    tron_round_ctrl #(
        .STEP_FRAMES      (STEP_FRAMES),
        .COUNTDOWN_FRAMES (COUNTDOWN_FRAMES),
        .ROUND_END_FRAMES (ROUND_END_FRAMES),
        .WIN_SCORE        (WIN_SCORE)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .frame_end   (frame_end),
        .crash_p1    (crash_p1),
        .crash_p2    (crash_p2),
        .clear_done  (clear_done),
        .clear_req   (clear_req),
        .step_en     (step_en),
        .play_active (play_active),
        .state       (state),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .winner      (winner)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) if (step_en === 1'b1) step_seen++;

    assign dut_vec = {state, score_p1, score_p2, winner, clear_req, step_en, play_active};

    function automatic logic [15:0] model_vec();
        return {3'(m_state), 4'(m_s1), 4'(m_s2), 2'(m_winner), m_clear_req, m_step, m_play};
    endfunction

    function automatic void model_step(bit st, bit fe, bit c1, bit c2, bit cd, bit rst);
        int ns;
        bit stp;
        ns  = m_state;
        stp = 0;
        if (rst) begin
            m_state = 0; m_frames = 0; m_s1 = 0; m_s2 = 0; m_winner = 0;
            m_clear_req = 0; m_step = 0; m_play = 0;
            return;
        end
        case (m_state)
            0, 5: if (st) begin ns = 1; m_s1 = 0; m_s2 = 0; m_winner = 0; end
            1: if (cd) ns = 2;
            2: if (fe) begin
                m_frames++;
                if (m_frames == COUNTDOWN_FRAMES) ns = 3;
            end
            3: begin
                if (c1 && c2) begin
                    ns = 4; m_winner = 3;
                end else if (c1) begin
                    ns = 4; m_winner = 2;
                    if (m_s2 < WIN_SCORE) m_s2++;
                end else if (c2) begin
                    ns = 4; m_winner = 1;
                    if (m_s1 < WIN_SCORE) m_s1++;
                end else if (fe) begin
                    m_frames++;
                    stp = (m_frames % STEP_FRAMES) == 0;
                end
            end
            4: if (fe) begin
                m_frames++;
                if (m_frames == ROUND_END_FRAMES)
                    ns = (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) ? 5 : 1;
            end
            default: ns = 0;
        endcase
        if (ns != m_state) m_frames = 0;
        m_state     = ns;
        m_clear_req = (ns == 1);
        m_play      = (ns == 3);
        m_step      = stp;
    endfunction

    task automatic tick(input bit st, input bit fe, input bit c1, input bit c2, input bit cd);
        start = st; frame_end = fe; crash_p1 = c1; crash_p2 = c2; clear_done = cd;
        @(posedge CLOCK_50);
        model_step(st, fe, c1, c2, cd, reset);
        #1;
        start = 0; frame_end = 0; crash_p1 = 0; crash_p2 = 0; clear_done = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        idle($urandom_range(1, 3));
        tick(0, 1, 0, 0, 0);
    endtask

    task automatic enter_play();
        idle($urandom_range(0, 4));
        tick(0, 0, 0, 0, 1);
        repeat (COUNTDOWN_FRAMES) frame();
    endtask

    task automatic test_reset();
        reset = 1;
        idle(3);
        check_count++;
        if (dut_vec !== 16'h0) $display("FAIL reset_outputs got %h want %h", dut_vec, 16'h0);
        else pass_count++;
        reset = 0;
        idle(2);
        check_count++;
        if (dut_vec !== model_vec()) $display("FAIL idle_hold got %h want %h", dut_vec, model_vec());
        else pass_count++;
        $display("test_reset done: state=%0d", state);
    endtask

    task automatic test_round_start();
        int high;
        tick(1, 0, 0, 0, 0);
        check_count++;
        if ({state, clear_req} !== {3'd1, 1'b1})
            $display("FAIL start_to_clear got state=%0d clear_req=%b want 1/1", state, clear_req);
        else pass_count++;
        high = int'(clear_req);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0);
            high += int'(clear_req);
        end
        tick(0, 0, 0, 0, 1);
        high += int'(clear_req);
        check_count++;
        if (high !== 6) $display("FAIL clear_req_width got %0d want 6", high);
        else pass_count++;
        check_count++;
        if (dut_vec !== model_vec()) $display("FAIL clear_to_countdown got %h want %h", dut_vec, model_vec());
        else pass_count++;
        for (int f = 1; f <= COUNTDOWN_FRAMES; f++) begin
            frame();
            check_count++;
            if (state !== ((f < COUNTDOWN_FRAMES) ? 3'd2 : 3'd3))
                $display("FAIL countdown_frame%0d got state=%0d", f, state);
            else pass_count++;
        end
        check_count++;
        if (dut_vec !== model_vec()) $display("FAIL enter_playing got %h want %h", dut_vec, model_vec());
        else pass_count++;
        $display("test_round_start done: clear_req high %0d cycles, state=%0d", high, state);
    endtask

    task automatic test_step_pacing();
        int base;
        base = step_seen;
        for (int f = 1; f <= 6; f++) begin
            frame();
            check_count++;
            if (step_en !== ((f % STEP_FRAMES) == 0))
                $display("FAIL step_after_frame%0d got %b want %b", f, step_en, (f % STEP_FRAMES) == 0);
            else pass_count++;
            check_count++;
            if (dut_vec !== model_vec()) $display("FAIL step_model_frame%0d got %h want %h", f, dut_vec, model_vec());
            else pass_count++;
            tick(0, 0, 0, 0, 0);
            check_count++;
            if (step_en !== 1'b0) $display("FAIL step_width_frame%0d got %b want 0", f, step_en);
            else pass_count++;
        end
        check_count++;
        if (step_seen - base !== 3) $display("FAIL step_count got %0d want 3", step_seen - base);
        else pass_count++;
        $display("test_step_pacing done: %0d step pulses", step_seen - base);
    endtask

    task automatic test_draw();
        frame();
        check_count++;
        if (step_en !== 1'b0) $display("FAIL draw_odd_frame step got %b want 0", step_en);
        else pass_count++;
        idle(1);
        tick(0, 1, 1, 1, 0);
        check_count++;
        if ({state, winner, score_p1, score_p2, step_en} !== {3'd4, 2'd3, 4'd0, 4'd0, 1'b0})
            $display("FAIL draw_result got state=%0d winner=%0d s1=%0d s2=%0d step=%b want 4/3/0/0/0",
                     state, winner, score_p1, score_p2, step_en);
        else pass_count++;
        idle(1);
        check_count++;
        if (dut_vec !== model_vec()) $display("FAIL draw_model got %h want %h", dut_vec, model_vec());
        else pass_count++;
        frame();
        frame();
        check_count++;
        if (state !== 3'd1) $display("FAIL draw_round_end_exit got state=%0d want 1", state);
        else pass_count++;
        $display("test_draw done: winner=%0d state=%0d", winner, state);
    endtask

    task automatic test_scoring();
        enter_play();
        repeat ($urandom_range(0, 3)) frame();
        idle(1);
        tick(0, 0, 0, 1, 0);
        check_count++;
        if ({state, score_p1, score_p2, winner} !== {3'd4, 4'd1, 4'd0, 2'd1})
            $display("FAIL p1_point1 got state=%0d s1=%0d s2=%0d winner=%0d want 4/1/0/1",
                     state, score_p1, score_p2, winner);
        else pass_count++;
        frame();
        check_count++;
        if (state !== 3'd4) $display("FAIL round_end_hold got state=%0d want 4", state);
        else pass_count++;
        frame();
        check_count++;
        if (state !== 3'd1) $display("FAIL round_end_to_clear got state=%0d want 1", state);
        else pass_count++;
        enter_play();
        frame();
        tick(0, 0, 0, 1, 0);
        check_count++;
        if ({state, score_p1, score_p2, winner} !== {3'd4, 4'd2, 4'd0, 2'd1})
            $display("FAIL p1_point2 got state=%0d s1=%0d s2=%0d winner=%0d want 4/2/0/1",
                     state, score_p1, score_p2, winner);
        else pass_count++;
        frame();
        frame();
        check_count++;
        if (state !== 3'd5) $display("FAIL game_over_entry got state=%0d want 5", state);
        else pass_count++;
        check_count++;
        if (dut_vec !== model_vec()) $display("FAIL game_over_model got %h want %h", dut_vec, model_vec());
        else pass_count++;
        $display("test_scoring done: s1=%0d s2=%0d state=%0d", score_p1, score_p2, state);
    endtask

    task automatic test_game_over();
        for (int i = 0; i < 4; i++) begin
            tick(0, 1'($urandom_range(0, 1)), 1, 1'(i % 2), 0);
            check_count++;
            if ({state, score_p1, score_p2, winner} !== {3'd5, 4'd2, 4'd0, 2'd1})
                $display("FAIL game_over_crash%0d got state=%0d s1=%0d s2=%0d winner=%0d want 5/2/0/1",
                         i, state, score_p1, score_p2, winner);
            else pass_count++;
        end
        tick(1, 0, 0, 0, 0);
        check_count++;
        if ({state, score_p1, score_p2, winner, clear_req} !== {3'd1, 4'd0, 4'd0, 2'd0, 1'b1})
            $display("FAIL game_over_restart got state=%0d s1=%0d s2=%0d winner=%0d clear_req=%b want 1/0/0/0/1",
                     state, score_p1, score_p2, winner, clear_req);
        else pass_count++;
        $display("test_game_over done: state=%0d", state);
    endtask

    task automatic test_ignored_and_reset();
        enter_play();
        tick(1, 0, 0, 0, 0);
        check_count++;
        if ({state, play_active} !== {3'd3, 1'b1})
            $display("FAIL start_in_playing got state=%0d play_active=%b want 3/1", state, play_active);
        else pass_count++;
        idle(1);
        tick(0, 0, 1, 0, 0);
        check_count++;
        if ({state, score_p2, winner} !== {3'd4, 4'd1, 2'd2})
            $display("FAIL p2_point got state=%0d s2=%0d winner=%0d want 4/1/2", state, score_p2, winner);
        else pass_count++;
        frame();
        frame();
        idle(2);
        tick(0, 0, 0, 0, 1);
        frame();
        check_count++;
        if (state !== 3'd2) $display("FAIL countdown_before_reset got state=%0d want 2", state);
        else pass_count++;
        reset = 1;
        tick(0, 0, 0, 0, 0);
        reset = 0;
        check_count++;
        if (dut_vec !== 16'h0) $display("FAIL reset_in_countdown got %h want %h", dut_vec, 16'h0);
        else pass_count++;
        $display("test_ignored_and_reset done: state=%0d", state);
    endtask

    task automatic test_random();
        bit cd_level;
        int bad;
        cd_level = 0;
        bad = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 5) == 0) cd_level = ~cd_level;
            reset = ($urandom_range(0, 499) == 0);
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, cd_level);
            check_count++;
            if (dut_vec !== model_vec()) begin
                bad++;
                $display("FAIL random_cycle%0d got %h want %h", cyc, dut_vec, model_vec());
            end else pass_count++;
        end
        reset = 0;
        $display("test_random done: %0d mismatching cycles", bad);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_start();
        test_step_pacing();
        test_draw();
        test_scoring();
        test_game_over();
        test_ignored_and_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
